cam_cfg_sequencer: RTL and testbench
====================================

CAM_CFG_SEQUENCER -- requirements
Module: cam_cfg_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter ROM_DEPTH, default 256, number of configuration ROM entries (power of two, max 256).
REQ-003 SHALL have parameter MAX_RETRY, default 3, number of re-attempts per NACKed write.
REQ-004 SHALL have port i_sysclk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_cfg_start, input, 1 bit: single-cycle pulse that starts a configuration pass.
REQ-007 SHALL have port o_rom_addr, output, 8 bits: configuration ROM read address.
REQ-008 SHALL have port i_rom_data, input, 16 bits: ROM word {reg_addr[15:8], reg_value[7:0]}, valid one cycle after o_rom_addr changes.
REQ-009 SHALL have port o_sccb_start, output, 1 bit: write request to the SCCB master.
REQ-010 SHALL have port o_sccb_addr, output, 8 bits: camera register address.
REQ-011 SHALL have port o_sccb_data, output, 8 bits: camera register value.
REQ-012 SHALL have port i_sccb_ready, input, 1 bit: SCCB master idle and able to accept a request.
REQ-013 SHALL have port i_sccb_done, input, 1 bit: single-cycle pulse ending a write transaction.
REQ-014 SHALL have port i_sccb_nack, input, 1 bit: slave NACK; sampled only when i_sccb_done=1.
REQ-015 SHALL have port o_busy, output, 1 bit: high while a pass is in progress.
REQ-016 SHALL have port o_done, output, 1 bit: high from successful completion until the next start or reset.
REQ-017 SHALL have port o_error, output, 1 bit: high from abort until the next start or reset.

Function
REQ-018 SHALL implement the states IDLE, FETCH, DECODE, WRITE, WAIT_ACK, DELAY, DONE and ERROR.
REQ-019 SHALL, on i_cfg_start in IDLE, DONE or ERROR, clear o_done, o_error, o_rom_addr and the retry count, then enter FETCH; i_cfg_start in any other state SHALL be ignored.
REQ-020 SHALL spend exactly one cycle in FETCH (ROM latency) and then enter DECODE.
REQ-021 SHALL decode each ROM word as follows: 16'hFFFF is the end marker and leads to DONE; reg_addr 8'hFF with any other value leads to DELAY of reg_value milliseconds; any other word leads to WRITE.
REQ-022 SHALL skip a DELAY entry with value 0 without waiting (advance directly to the next entry).
REQ-023 SHALL, in DELAY, count CLK_FREQ/1000 cycles per millisecond, with the total count width sized for 255 ms.
REQ-024 SHALL, in WRITE, register o_sccb_addr and o_sccb_data from the ROM word and assert o_sccb_start for exactly one cycle, in the first cycle with i_sccb_ready=1, then enter WAIT_ACK.
REQ-025 SHALL, in WAIT_ACK, on i_sccb_done with i_sccb_nack=0, clear the retry count and advance.
REQ-026 SHALL advance by incrementing o_rom_addr and entering FETCH; if o_rom_addr is ROM_DEPTH-1, it SHALL enter DONE instead, without wrapping.
REQ-027 SHALL keep o_sccb_addr and o_sccb_data stable from start until i_sccb_done.
REQ-028 SHALL hold o_busy=1 in FETCH, DECODE, WRITE, WAIT_ACK and DELAY, and 0 otherwise.
REQ-029 SHALL hold o_busy, o_done and o_error mutually exclusive, with o_done=1 only in DONE and o_error=1 only in ERROR.
REQ-030 SHALL ignore i_sccb_done outside WAIT_ACK.

Reset
REQ-031 SHALL, on i_rst=1, force state=IDLE and drive o_rom_addr=0, o_sccb_start=0, o_sccb_addr=0, o_sccb_data=0, o_busy=0, o_done=0, o_error=0, and clear the retry and delay counters.
REQ-032 SHALL abort any pass in progress when reset is applied mid-operation (no further o_sccb_start) and SHALL NOT auto-restart after reset.
REQ-033 SHALL give i_rst priority over i_cfg_start in the same cycle.

Configuration
REQ-034 SHALL, with macro CAM_CFG_RETRY_EN defined, on a NACK return to WRITE (same entry) while retry count < MAX_RETRY, incrementing the count, and enter ERROR once the count equals MAX_RETRY.
REQ-035 SHALL, without CAM_CFG_RETRY_EN, enter ERROR on the first NACK and omit all retry logic.
REQ-036 SHALL, in ERROR, hold o_rom_addr at the failing entry for debug.

Verification
REQ-037 SHALL cover: ROM {1280, 12A4, FFFF}, ready=1, done after 10 cycles with no NACK -> two start pulses (addr 12/data 80, then 12/A4), then o_done=1 and o_busy=0.
REQ-038 SHALL cover: ROM {FF02, 1101, FFFF} with CLK_FREQ=1000 -> first start pulse no earlier than 2 cycles after the DELAY entry is decoded.
REQ-039 SHALL cover: NACK on every attempt with CAM_CFG_RETRY_EN defined -> exactly 4 start pulses for the entry, then o_error=1 with o_rom_addr=0.
REQ-040 SHALL cover: the same NACK stimulus without the macro -> 1 start pulse, then o_error=1.
REQ-041 SHALL cover: i_rst asserted while in WAIT_ACK -> all outputs 0 next cycle, and no further start pulses until i_cfg_start.
REQ-042 SHALL cover: ROM_DEPTH=4 with no end marker -> 4 writes, then o_done=1 with o_rom_addr=3.

Source files
------------

// File: rtl/cam_cfg_sequencer_if.sv
// rtl/cam_cfg_sequencer_if.sv - SCCB write-request bus between the config sequencer and the SCCB master
interface cam_cfg_sequencer_if;
  logic       o_sccb_start;
  logic [7:0] o_sccb_addr;
  logic [7:0] o_sccb_data;
  logic       i_sccb_ready;
  logic       i_sccb_done;
  logic       i_sccb_nack;

  modport master (
    output o_sccb_start,
    output o_sccb_addr,
    output o_sccb_data,
    input  i_sccb_ready,
    input  i_sccb_done,
    input  i_sccb_nack
  );

  modport slave (
    input  o_sccb_start,
    input  o_sccb_addr,
    input  o_sccb_data,
    output i_sccb_ready,
    output i_sccb_done,
    output i_sccb_nack
  );
endinterface

// File: rtl/cam_cfg_sequencer.sv
// rtl/cam_cfg_sequencer.sv - ROM-driven camera register sequencer issuing SCCB writes; NACK retry enabled by CAM_CFG_RETRY_EN
module cam_cfg_sequencer #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int ROM_DEPTH = 256,
  parameter int MAX_RETRY = 3
) (
  input  logic                       i_sysclk,
  input  logic                       i_rst,
  input  logic                       i_cfg_start,
  output logic [7:0]                 o_rom_addr,
  input  logic [15:0]                i_rom_data,
  cam_cfg_sequencer_if.master        sccb,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error
);

  // One millisecond of clock cycles; never below one so tiny test clocks still count.
  localparam int CYC_PER_MS = ((CLK_FREQ / 1000) < 1) ? 1 : (CLK_FREQ / 1000);
  // Delay counter holds up to 255 ms worth of cycles; at least 9 bits so the
  // zero-extension of the 8-bit ms value below is always well formed.
  localparam int DLY_RAW = $clog2(255 * CYC_PER_MS + 1);
  localparam int DLY_W   = (DLY_RAW < 9) ? 9 : DLY_RAW;
  localparam logic [DLY_W-1:0] CYC_PER_MS_W = DLY_W'(CYC_PER_MS);
  localparam logic [7:0]       LAST_ADDR    = 8'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WRITE,
    WAIT_ACK,
    DELAY,
    DONE,
    ERROR
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_rom_addr;
  logic             r_sccb_start;
  logic [7:0]       r_sccb_addr;
  logic [7:0]       r_sccb_data;
  logic [DLY_W-1:0] r_delay_cnt;

  logic             w_start_pass;
  logic             w_advance;
  logic             w_load_write;
  logic             w_load_delay;
  logic             w_is_end;
  logic             w_is_delay;
  logic             w_at_last;
  logic [DLY_W-1:0] w_delay_load;

`ifdef CAM_CFG_RETRY_EN
  localparam int RTRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTRY_W-1:0] r_retry_cnt;
  logic              w_retry_inc;
  logic              w_retry_clr;
`endif

  assign w_is_end     = (i_rom_data == 16'hFFFF);
  assign w_is_delay   = (i_rom_data[15:8] == 8'hFF);
  assign w_at_last    = (r_rom_addr == LAST_ADDR);
  // Delay is loaded as (ms * cycles_per_ms) - 1 so DELAY lasts exactly that many cycles.
  assign w_delay_load = ({{(DLY_W-8){1'b0}}, i_rom_data[7:0]} * CYC_PER_MS_W) - DLY_W'(1);

  // State register.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_start_pass = 1'b0;
    w_advance    = 1'b0;
    w_load_write = 1'b0;
    w_load_delay = 1'b0;
`ifdef CAM_CFG_RETRY_EN
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
`endif
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (i_cfg_start) begin
          w_start_pass = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        w_next_state = DECODE;
      end
      DECODE: begin
        if (w_is_end) begin
          w_next_state = DONE;
        end else if (w_is_delay) begin
          // A zero-length delay costs nothing beyond its fetch/decode.
          if (i_rom_data[7:0] == 8'h00) begin
            w_advance = 1'b1;
          end else begin
            w_load_delay = 1'b1;
            w_next_state = DELAY;
          end
        end else begin
          w_load_write = 1'b1;
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        if (sccb.i_sccb_ready) begin
          w_next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sccb.i_sccb_done) begin
          if (!sccb.i_sccb_nack) begin
`ifdef CAM_CFG_RETRY_EN
            w_retry_clr = 1'b1;
`endif
            w_advance = 1'b1;
`ifdef CAM_CFG_RETRY_EN
          end else if (r_retry_cnt < RTRY_W'(MAX_RETRY)) begin
            w_retry_inc  = 1'b1;
            w_next_state = WRITE;
`endif
          end else begin
            w_next_state = ERROR;
          end
        end
      end
      DELAY: begin
        if (r_delay_cnt == '0) begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    // Moving to the next entry stops at the last ROM word instead of wrapping.
    if (w_advance) begin
      w_next_state = w_at_last ? DONE : FETCH;
    end
  end

  // ROM address, SCCB request registers and delay counter.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_rom_addr   <= '0;
      r_sccb_start <= 1'b0;
      r_sccb_addr  <= '0;
      r_sccb_data  <= '0;
      r_delay_cnt  <= '0;
    end else begin
      // Start pulses in the first WRITE cycle with ready; WRITE is left on that same edge.
      r_sccb_start <= (r_state == WRITE) && sccb.i_sccb_ready;

      if (w_start_pass) begin
        r_rom_addr <= '0;
      end else if (w_advance && !w_at_last) begin
        r_rom_addr <= r_rom_addr + 8'd1;
      end

      // Address/data only reload in DECODE, so they stay put through WAIT_ACK and retries.
      if (w_load_write) begin
        r_sccb_addr <= i_rom_data[15:8];
        r_sccb_data <= i_rom_data[7:0];
      end

      if (w_start_pass) begin
        r_delay_cnt <= '0;
      end else if (w_load_delay) begin
        r_delay_cnt <= w_delay_load;
      end else if ((r_state == DELAY) && (r_delay_cnt != '0)) begin
        r_delay_cnt <= r_delay_cnt - DLY_W'(1);
      end
    end
  end

`ifdef CAM_CFG_RETRY_EN
  // Per-entry NACK retry counter.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_retry_cnt <= '0;
    end else if (w_start_pass || w_retry_clr) begin
      r_retry_cnt <= '0;
    end else if (w_retry_inc) begin
      r_retry_cnt <= r_retry_cnt + RTRY_W'(1);
    end
  end
`endif

  assign o_rom_addr        = r_rom_addr;
  assign sccb.o_sccb_start = r_sccb_start;
  assign sccb.o_sccb_addr  = r_sccb_addr;
  assign sccb.o_sccb_data  = r_sccb_data;
  assign o_busy  = (r_state == FETCH) || (r_state == DECODE) || (r_state == WRITE) ||
                   (r_state == WAIT_ACK) || (r_state == DELAY);
  assign o_done  = (r_state == DONE);
  assign o_error = (r_state == ERROR);

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb/tb_cam_cfg_sequencer.sv - self-checking bench for cam_cfg_sequencer
module tb_cam_cfg_sequencer;
  localparam int CLK_FREQ  = 1000;
  localparam int ROM_DEPTH = 4;
  localparam int MAX_RETRY = 3;
  localparam int CYC_MS    = CLK_FREQ / 1000;
`ifdef CAM_CFG_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_q = 16'h0000;
  logic        busy;
  logic        done_o;
  logic        err_o;
  logic [15:0] rom_mem [ROM_DEPTH];

  cam_cfg_sequencer_if sccb_if ();

  cam_cfg_sequencer #(
    .CLK_FREQ (CLK_FREQ),
    .ROM_DEPTH(ROM_DEPTH),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_sysclk   (clk),
    .i_rst      (rst),
    .i_cfg_start(cfg_start),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_q),
    .sccb       (sccb_if),
    .o_busy     (busy),
    .o_done     (done_o),
    .o_error    (err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: word appears one clock after the address.
  always @(posedge clk) rom_q <= rom_mem[int'(rom_addr) % ROM_DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SCCB slave model state
  int          lat_cfg = 10;
  int          pend = 0;
  logic [63:0] nack_vec = '0;
  int          nack_idx = 0;
  bit          rand_ready = 1'b0;
  bit          spur_req = 1'b0;
  logic [7:0]  wr_a [$];
  logic [7:0]  wr_d [$];
  int          wr_cyc [$];
  logic [7:0]  cur_a = 8'h00;
  logic [7:0]  cur_d = 8'h00;

  initial begin
    sccb_if.i_sccb_ready = 1'b0;
    sccb_if.i_sccb_done  = 1'b0;
    sccb_if.i_sccb_nack  = 1'b0;
    forever begin
      @(negedge clk);
      sccb_if.i_sccb_done = 1'b0;
      sccb_if.i_sccb_nack = 1'b0;
      if (rst) begin
        pend = 0;
      end else if (sccb_if.o_sccb_start) begin
        check("start_while_busy", pend, 0);
        wr_a.push_back(sccb_if.o_sccb_addr);
        wr_d.push_back(sccb_if.o_sccb_data);
        wr_cyc.push_back(cyc);
        cur_a = sccb_if.o_sccb_addr;
        cur_d = sccb_if.o_sccb_data;
        pend  = lat_cfg;
      end else if (pend > 0) begin
        check("sccb_addr_stable", sccb_if.o_sccb_addr, cur_a);
        check("sccb_data_stable", sccb_if.o_sccb_data, cur_d);
        pend--;
        if (pend == 0) begin
          sccb_if.i_sccb_done = 1'b1;
          sccb_if.i_sccb_nack = (nack_idx < 64) ? nack_vec[nack_idx] : 1'b0;
          nack_idx++;
        end
      end else if (spur_req) begin
        sccb_if.i_sccb_done = 1'b1;
        sccb_if.i_sccb_nack = 1'b1;
        spur_req = 1'b0;
      end
      sccb_if.i_sccb_ready = (pend == 0) && (!rand_ready || ($urandom_range(0, 3) != 0));
    end
  end

  task automatic clear_slave();
    wr_a.delete();
    wr_d.delete();
    wr_cyc.delete();
    nack_idx = 0;
  endtask

  task automatic load_rom(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    rom_mem[0] = a;
    rom_mem[1] = b;
    rom_mem[2] = c;
    rom_mem[3] = d;
  endtask

  task automatic pulse_start(output int s);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n;
    n = 0;
    while (!(done_o || err_o) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish_in_budget"}, (done_o || err_o), 1);
  endtask

  initial begin
    int          ws;
    int          n;
    int          idx;
    int          tries;
    int          exp_addr;
    int          t;
    bit          ok;
    bit          fin;
    bit          nk;
    bit          exp_err;
    logic [15:0] w;
    logic [7:0]  ea [$];
    logic [7:0]  ed [$];

    for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = 16'hFFFF;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_o, 0);
    check("rst_error", err_o, 0);
    check("rst_start", sccb_if.o_sccb_start, 0);
    check("rst_sccb_addr", sccb_if.o_sccb_addr, 0);
    check("rst_sccb_data", sccb_if.o_sccb_data, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_autostart", busy, 0);

    // Two writes then end marker, 10-cycle acknowledge
    load_rom(16'h1280, 16'h12A4, 16'hFFFF, 16'h0000);
    lat_cfg = 10; nack_vec = '0; rand_ready = 1'b0; clear_slave();
    pulse_start(ws);
    check("a_busy_running", busy, 1);
    wait_end(400, "a");
    check("a_n_writes", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      check("a_w0_addr", wr_a[0], 8'h12);
      check("a_w0_data", wr_d[0], 8'h80);
      check("a_w1_addr", wr_a[1], 8'h12);
      check("a_w1_data", wr_d[1], 8'hA4);
    end
    check("a_done", done_o, 1);
    check("a_busy", busy, 0);
    check("a_error", err_o, 0);
    check("a_rom_addr", rom_addr, 2);
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    check("a_spurious_done_done", done_o, 1);
    check("a_spurious_done_error", err_o, 0);

    // 2 ms delay ahead of a write
    load_rom(16'hFF02, 16'h1101, 16'hFFFF, 16'hFFFF);
    lat_cfg = 3; clear_slave();
    pulse_start(ws);
    check("b_done_cleared", done_o, 0);
    wait_end(400, "b");
    check("b_n_writes", wr_a.size(), 1);
    if (wr_a.size() == 1) begin
      check("b_w0_addr", wr_a[0], 8'h11);
      check("b_w0_data", wr_d[0], 8'h01);
      // DELAY entry decodes in cycle ws+1; its start must come at least 2 ms later
      check("b_delay_before_start", (wr_cyc[0] - ws) >= (1 + 2 * CYC_MS), 1);
    end
    check("b_done", done_o, 1);

    // Exact duration: every entry costs fetch+decode plus its delay (0 ms skipped)
    load_rom(16'hFF03, 16'hFF00, 16'hFF01, 16'hFFFF);
    clear_slave();
    pulse_start(ws);
    n = 0;
    while (!done_o && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("c_done_cycles", cyc - ws, 2 * 4 + (3 + 0 + 1) * CYC_MS);
    check("c_n_writes", wr_a.size(), 0);
    check("c_rom_addr", rom_addr, 3);

    // NACK on every attempt
    load_rom(16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    lat_cfg = 3; nack_vec = '1; clear_slave();
    pulse_start(ws);
    wait_end(600, "d");
    check("d_n_attempts", wr_a.size(), RETRIES + 1);
    foreach (wr_a[k]) begin
      check("d_attempt_addr", wr_a[k], 8'h12);
      check("d_attempt_data", wr_d[k], 8'h34);
    end
    check("d_error", err_o, 1);
    check("d_done", done_o, 0);
    check("d_busy", busy, 0);
    check("d_rom_addr", rom_addr, 0);

    // Restart from ERROR; no end marker, stops at last ROM word
    load_rom(16'h1001, 16'h1102, 16'h1203, 16'h1304);
    nack_vec = '0; clear_slave();
    pulse_start(ws);
    check("e_error_cleared", err_o, 0);
    wait_end(600, "e");
    check("e_n_writes", wr_a.size(), 4);
    foreach (wr_a[k]) begin
      check("e_addr", wr_a[k], 8'h10 + 8'(k));
      check("e_data", wr_d[k], 8'h01 + 8'(k));
    end
    check("e_done", done_o, 1);
    check("e_rom_addr", rom_addr, 3);

    // Reset while waiting for acknowledge
    load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    lat_cfg = 40; clear_slave();
    pulse_start(ws);
    n = 0;
    while ((wr_a.size() < 1) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check("f_first_write", wr_a.size(), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("f_rst_start", sccb_if.o_sccb_start, 0);
    check("f_rst_sccb_addr", sccb_if.o_sccb_addr, 0);
    check("f_rst_sccb_data", sccb_if.o_sccb_data, 0);
    check("f_rst_busy", busy, 0);
    check("f_rst_done", done_o, 0);
    check("f_rst_error", err_o, 0);
    check("f_rst_rom_addr", rom_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("f_no_more_writes", wr_a.size(), 1);
    check("f_idle_busy", busy, 0);

    // Reset wins over a simultaneous start
    clear_slave();
    rst = 1'b1;
    cfg_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cfg_start = 1'b0;
    repeat (6) @(negedge clk);
    check("g_rst_priority_busy", busy, 0);
    check("g_rst_priority_writes", wr_a.size(), 0);

    // Randomized ROM contents, latency, ready and NACK pattern against a reference walk
    lat_cfg = 2;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < ROM_DEPTH; i++) begin
        t = $urandom_range(0, 9);
        if (t == 0) rom_mem[i] = 16'hFFFF;
        else if (t <= 2) rom_mem[i] = {8'hFF, 8'($urandom_range(0, 4))};
        else rom_mem[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
      end
      nack_vec = {$urandom, $urandom} & {$urandom, $urandom};
      lat_cfg = $urandom_range(1, 6);
      rand_ready = 1'b1;
      clear_slave();

      ea.delete();
      ed.delete();
      exp_err = 1'b0;
      exp_addr = ROM_DEPTH - 1;
      idx = 0;
      fin = 1'b0;
      for (int i = 0; (i < ROM_DEPTH) && !fin; i++) begin
        w = rom_mem[i];
        if (w == 16'hFFFF) begin
          exp_addr = i;
          fin = 1'b1;
        end else if (w[15:8] != 8'hFF) begin
          tries = 0;
          ok = 1'b0;
          while (!ok && !fin) begin
            ea.push_back(w[15:8]);
            ed.push_back(w[7:0]);
            nk = (idx < 64) ? nack_vec[idx] : 1'b0;
            idx++;
            if (!nk) ok = 1'b1;
            else if (tries == RETRIES) begin
              exp_err = 1'b1;
              exp_addr = i;
              fin = 1'b1;
            end else tries++;
          end
        end
      end

      pulse_start(ws);
      wait_end(2000, "r");
      check("r_n_writes", wr_a.size(), ea.size());
      foreach (ea[k]) begin
        if (k < wr_a.size()) begin
          check("r_addr", wr_a[k], ea[k]);
          check("r_data", wr_d[k], ed[k]);
        end
      end
      check("r_done", done_o, !exp_err);
      check("r_error", err_o, exp_err);
      check("r_busy", busy, 0);
      check("r_rom_addr", rom_addr, exp_addr);
      repeat (2) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
